aurora_rx_lane: RTL and testbench

Single-lane Aurora 64B/66B receive back end. It samples a serial bit stream, one bit per clock, and frames 66-bit blocks by searching for valid sync headers with bit slips. It then descrambles the 64-bit payload and presents one block per valid strobe to the channel-bonding/framing logic above it.

---
 rtl/aurora_rx_lane.sv | 194 +++++++++++++++++++
 tb/tb_aurora_rx_lane.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_rx_lane.sv
// aurora_rx_lane: single-lane 64B/66B receive back end.
// Samples one serial bit per clock and frames 66-bit blocks by sync-header
// search with bit slips. It tracks block lock and delivers payloads.
// Optional feature: define AURORA_RX_DESCRAMBLE_EN to descramble the payload
// with the self-synchronous 1+x^39+x^58 descrambler. When the macro is
// undefined, the raw framed payload is delivered.
module aurora_rx_lane #(
   parameter int unsigned LOCK_CNT = 32,
   parameter int unsigned WIN_LEN  = 64,
   parameter int unsigned BAD_MAX  = 16
) (
   input  logic        clk_rx_i,
   input  logic        rst_n_i,
   input  logic        rx_data_i_p,
   input  logic        rx_data_i_n,
   input  logic        rx_polarity_i,
   output logic [63:0] rx_data_o,
   output logic [1:0]  rx_header_o,
   output logic        rx_valid_o,
   output logic [7:0]  rx_stat_o
);

   localparam int unsigned GW = $clog2(LOCK_CNT + 1);
   localparam int unsigned BW = $clog2(BAD_MAX + 1);
   localparam int unsigned WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam logic [GW-1:0] LOCK_V   = GW'(LOCK_CNT);
   localparam logic [BW-1:0] BAD_V    = BW'(BAD_MAX);
   localparam logic [WW-1:0] WIN_LAST = WW'(WIN_LEN - 1);

   typedef enum logic {ST_HUNT, ST_LOCKED} lock_state_t;

   lock_state_t   state, state_nx;
   logic          bit_q;
   logic          primed;
   logic [65:0]   sr;
   logic [6:0]    frame_cnt;
   logic          blk_stb;
   logic [GW-1:0] good_cnt, good_nx;
   logic [BW-1:0] bad_cnt, bad_nx;
   logic [WW-1:0] win_cnt, win_nx;
   logic [5:0]    slip_cnt;
   logic          hdr_bad;
   logic          hdr_ok;
   logic          slip;
   logic          deliver;
   logic [63:0]   payload;
   logic          unused_pin;

   assign unused_pin = rx_data_i_n;
   assign hdr_ok     = sr[65] ^ sr[64];
   assign rx_stat_o  = {slip_cnt, hdr_bad, (state == ST_LOCKED)};

   // Register the polarity-corrected bit, then shift it in MSB-first.
   always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         bit_q <= 1'b0;
         sr    <= '0;
      end else begin
         bit_q <= rx_data_i_p ^ rx_polarity_i;
         sr    <= {sr[64:0], bit_q};
      end
   end

   // Framing counter tracks the block bit held in bit_q. The first edge after
   // reset only loads bit_q. A slip holds the counter on the edge that
   // evaluates the block, pushing the next boundary one bit later.
   always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         primed    <= 1'b0;
         frame_cnt <= '0;
         blk_stb   <= 1'b0;
      end else begin
         blk_stb <= (frame_cnt == 7'd65);
         if (!primed) begin
            primed <= 1'b1;
         end else if (!slip) begin
            frame_cnt <= (frame_cnt == 7'd65) ? 7'd0 : frame_cnt + 7'd1;
         end
      end
   end

   // Lock state and its header counters.
   always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= ST_HUNT;
         good_cnt <= '0;
         bad_cnt  <= '0;
         win_cnt  <= '0;
      end else begin
         state    <= state_nx;
         good_cnt <= good_nx;
         bad_cnt  <= bad_nx;
         win_cnt  <= win_nx;
      end
   end

   // Evaluate each framed header: count toward lock, watch the loss window,
   // and decide slip and delivery for this block.
   always_comb begin
      state_nx = state;
      good_nx  = good_cnt;
      bad_nx   = bad_cnt;
      win_nx   = win_cnt;
      slip     = 1'b0;
      deliver  = 1'b0;
      if (blk_stb) begin
         unique case (state)
            ST_HUNT: begin
               if (hdr_ok) begin
                  good_nx = good_cnt + GW'(1);
                  if (good_nx == LOCK_V) begin
                     state_nx = ST_LOCKED;
                     deliver  = 1'b1;
                     bad_nx   = '0;
                     win_nx   = '0;
                  end
               end else begin
                  good_nx = '0;
                  slip    = 1'b1;
               end
            end
            ST_LOCKED: begin
               deliver = hdr_ok;
               if (!hdr_ok) begin
                  bad_nx = bad_cnt + BW'(1);
               end
               if (bad_nx == BAD_V) begin
                  state_nx = ST_HUNT;
                  good_nx  = '0;
                  slip     = 1'b1;
               end else if (win_cnt == WIN_LAST) begin
                  win_nx = '0;
                  bad_nx = '0;
               end else begin
                  win_nx = win_cnt + WW'(1);
               end
            end
         endcase
      end
   end

`ifdef AURORA_RX_DESCRAMBLE_EN
   logic [57:0] scr_s;
   logic [57:0] scr_nx;

   // Descramble bit 0 first. Scrambled input bits feed the state.
   always_comb begin
      scr_nx  = scr_s;
      payload = '0;
      for (int unsigned i = 0; i < 64; i++) begin
         payload[i] = sr[i] ^ scr_nx[38] ^ scr_nx[57];
         scr_nx     = {scr_nx[56:0], sr[i]};
      end
   end

   // Advance the descrambler on every framed block, locked or not.
   always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         scr_s <= '0;
      end else if (blk_stb) begin
         scr_s <= scr_nx;
      end
   end
`else
   // Pass the framed payload through unchanged.
   always_comb begin
      payload = sr[63:0];
   end
`endif

   // Register delivered blocks and the status fields.
   always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rx_data_o   <= '0;
         rx_header_o <= '0;
         rx_valid_o  <= 1'b0;
         hdr_bad     <= 1'b0;
         slip_cnt    <= '0;
      end else begin
         rx_valid_o <= deliver;
         if (deliver) begin
            rx_data_o   <= payload;
            rx_header_o <= sr[65:64];
         end
         if (blk_stb) begin
            hdr_bad <= !hdr_ok;
            if (slip && (slip_cnt != 6'd63)) begin
               slip_cnt <= slip_cnt + 6'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_aurora_rx_lane.sv
// Self-checking bench for aurora_rx_lane.
// The bench serialises 64B/66B blocks MSB-first and scrambles them in its own
// model. Each delivered block is predicted from the block whose final bit left
// the driver three cycles earlier.
module tb_aurora_rx_lane;

   localparam int unsigned LOCK_CNT = 32;
   localparam int unsigned WIN_LEN  = 64;
   localparam int unsigned BAD_MAX  = 16;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        din_p = 1'b0;
   logic        din_n = 1'b1;
   logic        pol   = 1'b0;
   logic [63:0] data;
   logic [1:0]  hdr;
   logic        valid;
   logic [7:0]  stat;

   aurora_rx_lane #(
      .LOCK_CNT(LOCK_CNT),
      .WIN_LEN (WIN_LEN),
      .BAD_MAX (BAD_MAX)
   ) dut (
      .clk_rx_i     (clk),
      .rst_n_i      (rst_n),
      .rx_data_i_p  (din_p),
      .rx_data_i_n  (din_n),
      .rx_polarity_i(pol),
      .rx_data_o    (data),
      .rx_header_o  (hdr),
      .rx_valid_o   (valid),
      .rx_stat_o    (stat)
   );

   always #5 clk = ~clk;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   // Stream model state.
   logic [65:0] blk_mem   [2048];
   logic [63:0] plain_mem [2048];
   logic [57:0] scr_state;
   int unsigned blk_idx;
   int unsigned bit_pos;
   bit          invert;
   bit          bad_mode;
   int          done_hist [4];
   int          last_idx;

   function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
      return (a < b) ? a : b;
   endfunction

   // Expected {header, payload} seen at the output for block idx.
   function automatic logic [65:0] exp_blk(input int idx);
      logic [65:0] b;
      b = blk_mem[idx % 2048];
`ifdef AURORA_RX_DESCRAMBLE_EN
      b[63:0] = plain_mem[idx % 2048];
`endif
      return b;
   endfunction

   task automatic make_block();
      logic [63:0] d;
      logic [63:0] s;
      logic [1:0]  h;
      if (bad_mode) begin
         h = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
         d = '0;
         s = '0;
      end else begin
         h = ((blk_idx % 64) == 0) ? 2'b01 : 2'b10;
         d = {blk_idx, blk_idx};
         for (int i = 0; i < 64; i++) begin
            s[i]      = d[i] ^ scr_state[38] ^ scr_state[57];
            scr_state = {scr_state[56:0], s[i]};
         end
      end
      blk_mem[blk_idx % 2048]   = {h, s};
      plain_mem[blk_idx % 2048] = d;
   endtask

   task automatic next_bit(output logic b, output int done);
      logic [65:0] cur;
      cur  = blk_mem[blk_idx % 2048];
      b    = cur[bit_pos];
      done = -1;
      if (bit_pos == 0) begin
         done    = int'(blk_idx);
         blk_idx = blk_idx + 1;
         bit_pos = 65;
         make_block();
      end else begin
         bit_pos = bit_pos - 1;
      end
   endtask

   // One clock: drive the next stream bit on the falling edge.
   task automatic step();
      logic b;
      int   d;
      @(negedge clk);
      next_bit(b, d);
      din_p        = b ^ invert;
      din_n        = ~din_p;
      done_hist[3] = done_hist[2];
      done_hist[2] = done_hist[1];
      done_hist[1] = done_hist[0];
      done_hist[0] = d;
   endtask

   task automatic restart(input int unsigned off, input bit inv, input bit bad);
      logic b;
      int   d;
      rst_n     = 1'b0;
      invert    = inv;
      pol       = inv;
      bad_mode  = bad;
      scr_state = '0;
      blk_idx   = 0;
      bit_pos   = 65;
      make_block();
      for (int unsigned j = 0; j < off; j++) next_bit(b, d);
      for (int j = 0; j < 4; j++) done_hist[j] = -1;
      repeat (2) @(negedge clk);
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (100) begin
         @(negedge clk);
         din_p = 1'($urandom_range(0, 1));
         din_n = ~din_p;
      end
      n_total++;
      if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid);
      else n_pass++;
      n_total++;
      if (data !== 64'h0) $display("FAIL reset_data: got %h expected 0", data);
      else n_pass++;
      n_total++;
      if (hdr !== 2'b00) $display("FAIL reset_header: got %b expected 00", hdr);
      else n_pass++;
      n_total++;
      if (stat !== 8'h00) $display("FAIL reset_stat: got %h expected 00", stat);
      else n_pass++;
   endtask

   // Aligned stream: every header valid, so lock lands on block LOCK_CNT-1.
   task automatic test_lock_aligned(input bit inv);
      bit          exp_v;
      logic [65:0] held;
      int          idx;
      restart(0, inv, 1'b0);
      held = '0;
      for (int s = 1; s <= 40 * 66; s++) begin
         step();
         idx   = done_hist[3];
         exp_v = (idx >= int'(LOCK_CNT) - 1);
         if (exp_v) held = exp_blk(idx);
         n_total++;
         if (valid !== exp_v)
            $display("FAIL aligned_valid inv=%0d step %0d: got %b expected %b", inv, s, valid, exp_v);
         else n_pass++;
         n_total++;
         if ({hdr, data} !== held)
            $display("FAIL aligned_data inv=%0d step %0d: got %h expected %h", inv, s, {hdr, data}, held);
         else n_pass++;
      end
      n_total++;
      if (stat !== 8'h01) $display("FAIL aligned_stat inv=%0d: got %h expected 01", inv, stat);
      else n_pass++;
      invert = 1'b0;
      pol    = 1'b0;
   endtask

   task automatic test_reset_midstream();
      bit seen;
      seen = 1'b0;
      for (int s = 0; s < 70 && !seen; s++) begin
         step();
         seen = valid;
      end
      n_total++;
      if (!seen) $display("FAIL midreset_strobe: got no strobe within 70 cycles, expected one");
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({valid, hdr, data, stat} !== 75'h0)
         $display("FAIL midreset_clear: got v=%b h=%b d=%h s=%h expected all 0", valid, hdr, data, stat);
      else n_pass++;
   endtask

   task automatic test_lock_offset();
      int unsigned off;
      int unsigned want_slip;
      bit          locked;
      int          idx;
      bit          exp_v;
      off    = $urandom_range(1, 65);
      restart(off, 1'b0, 1'b0);
      locked = 1'b0;
      for (int s = 0; s < int'((LOCK_CNT + 66) * 67) && !locked; s++) begin
         step();
         locked = stat[0];
      end
      n_total++;
      if (!locked) $display("FAIL offset_lock off=%0d: got no lock, expected lock", off);
      else n_pass++;
      idx = done_hist[3];
      n_total++;
      if (valid !== 1'b1 || idx < 0 || {hdr, data} !== exp_blk(idx))
         $display("FAIL offset_lock_block off=%0d: got v=%b %h expected v=1 block %0d", off, valid, {hdr, data}, idx);
      else n_pass++;
      want_slip = min_u(66 - off, 63);
      n_total++;
      if (stat[7:1] !== {6'(want_slip), 1'b0})
         $display("FAIL offset_stat off=%0d: got %h expected slips %0d hdr_bad 0", off, stat, want_slip);
      else n_pass++;
      last_idx = idx;
      for (int s = 0; s < 10 * 66; s++) begin
         step();
         idx   = done_hist[3];
         exp_v = (idx >= 0);
         n_total++;
         if (valid !== exp_v) $display("FAIL offset_valid step %0d: got %b expected %b", s, valid, exp_v);
         else n_pass++;
         if (valid && exp_v) begin
            last_idx = idx;
            n_total++;
            if ({hdr, data} !== exp_blk(idx))
               $display("FAIL offset_data block %0d: got %h expected %h", idx, {hdr, data}, exp_blk(idx));
            else n_pass++;
         end
      end
   endtask

   task automatic test_bit_drop();
      int   ks [3];
      bit   flag;
      int   idx;
      bit   exp_v;
      logic b;
      int   d;
      ks = '{0, int'($urandom_range(1, 64)), 65};
      for (int n = 0; n < 3; n++) begin
         for (int j = 0; j < ks[n]; j++) next_bit(b, d);
         if (ks[n] != 0) begin
            flag = 1'b1;
            for (int s = 0; s < int'(2 * WIN_LEN * 67) && flag; s++) begin
               step();
               flag = stat[0];
            end
            n_total++;
            if (flag || valid !== 1'b0)
               $display("FAIL drop_loss k=%0d: got lock=%b valid=%b expected 0 0", ks[n], flag, valid);
            else n_pass++;
            for (int s = 0; s < 500 * 67 && !flag; s++) begin
               step();
               flag = stat[0];
            end
            idx = done_hist[3];
            n_total++;
            if (!flag || valid !== 1'b1 || idx < 0 || {hdr, data} !== exp_blk(idx))
               $display("FAIL drop_relock k=%0d: got lock=%b v=%b %h expected block %0d", ks[n], flag, valid, {hdr, data}, idx);
            else n_pass++;
            n_total++;
            if (idx - last_idx < 1 || idx - last_idx > 600)
               $display("FAIL drop_jump k=%0d: got jump %0d expected 1..600", ks[n], idx - last_idx);
            else n_pass++;
            last_idx = idx;
         end
         for (int s = 0; s < 20 * 66; s++) begin
            step();
            idx   = done_hist[3];
            exp_v = (idx >= 0);
            n_total++;
            if (valid !== exp_v) $display("FAIL drop_valid k=%0d step %0d: got %b expected %b", ks[n], s, valid, exp_v);
            else n_pass++;
            if (valid && exp_v) begin
               n_total++;
               if ({hdr, data} !== exp_blk(idx) || idx != last_idx + 1)
                  $display("FAIL drop_data k=%0d block %0d: got %h expected %h", ks[n], idx, {hdr, data}, exp_blk(idx));
               else n_pass++;
               last_idx = idx;
            end
         end
         n_total++;
         if (stat[0] !== 1'b1) $display("FAIL drop_locked k=%0d: got %b expected 1", ks[n], stat[0]);
         else n_pass++;
      end
   endtask

   task automatic test_invalid_headers();
      bit saw_valid;
      bit saw_lock;
      restart(0, 1'b0, 1'b1);
      saw_valid = 1'b0;
      saw_lock  = 1'b0;
      for (int s = 0; s < 100 * 66; s++) begin
         step();
         if (valid === 1'b1) saw_valid = 1'b1;
         if (stat[0] === 1'b1) saw_lock = 1'b1;
      end
      n_total++;
      if (saw_valid) $display("FAIL invalid_valid: got a strobe, expected none");
      else n_pass++;
      n_total++;
      if (saw_lock) $display("FAIL invalid_lock: got lock, expected none");
      else n_pass++;
      n_total++;
      if (stat[7:2] !== 6'd63) $display("FAIL invalid_slips: got %0d expected 63", stat[7:2]);
      else n_pass++;
      bad_mode = 1'b0;
   endtask

   initial begin
      test_reset();
      test_lock_aligned(1'b0);
      test_reset_midstream();
      test_lock_aligned(1'b1);
      test_lock_offset();
      test_bit_drop();
      test_invalid_headers();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
